// File: rtl/rpn_alu_pkg.sv
// rpn_alu shared definitions: widths, opcodes,
// FSM states and error codes.
package rpn_alu_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 7;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_UNF  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_ILL  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POPB,
    S_CAPB,
    S_CAPA,
    S_PUSHR,
    S_PUSH2
  } state_t;

endpackage

// File: rtl/rpn_alu_if.sv
// rpn_alu command channel: opcode/immediate
// offered with valid, taken on valid && ready.
interface rpn_alu_if;
  import rpn_alu_pkg::*;

  logic              valid;
  logic              ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output op,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  op,
    input  data,
    output ready
  );

endinterface

// File: rtl/rpn_alu_exec.sv
// rpn_alu combinational result function (A, B, op).
// MUL is only built when RPN_ALU_MUL_EN is defined.
module rpn_alu_exec
  import rpn_alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_res
);

`ifdef RPN_ALU_MUL_EN
  logic [2*DATA_W-1:0] w_prod;
  assign w_prod = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
`endif

  // result select; non-arithmetic ops pass B through
  always_comb begin
    o_res = i_b;
    case (i_op)
      OP_ADD: o_res = i_a + i_b;
      OP_SUB: o_res = i_a - i_b;
      OP_AND: o_res = i_a & i_b;
      OP_XOR: o_res = i_a ^ i_b;
`ifdef RPN_ALU_MUL_EN
      OP_MUL: o_res = w_prod[DATA_W-1:0];
`endif
      default: o_res = i_b;
    endcase
  end

endmodule

// File: rtl/rpn_alu.sv
// rpn_alu top: RPN command FSM driving a LIFO stack.
// Define RPN_ALU_MUL_EN to make opcode 7 a multiply.
module rpn_alu
  import rpn_alu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  rpn_alu_if.slave          cmd,
  output logic              o_stk_push,
  output logic              o_stk_pop,
  output logic [DATA_W-1:0] o_stk_wdata,
  input  logic [DATA_W-1:0] i_stk_rdata,
  output logic              o_res_valid,
  output logic [DATA_W-1:0] o_res_data,
  output logic [CNT_W-1:0]  o_depth,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;
  logic [CNT_W-1:0]  r_depth;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_accept;
  logic [1:0]        w_pre_code;
  logic              w_push;
  logic              w_pop;
  logic              w_res_valid;
  logic [DATA_W-1:0] w_exec;

  assign cmd.ready = (r_state == S_IDLE) && !i_reset;
  assign w_accept  = cmd.valid && cmd.ready;

  rpn_alu_exec u_exec (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .o_res (w_exec)
  );

  // depth / legality check for the offered command
  always_comb begin
    w_pre_code = ERR_NONE;
    case (cmd.op)
      OP_PUSH: begin
        if (r_depth >= DEPTH_C) w_pre_code = ERR_OVF;
      end
      OP_POP: begin
        if (r_depth == '0) w_pre_code = ERR_UNF;
      end
      OP_DUP: begin
        if (r_depth == '0)
          w_pre_code = ERR_UNF;
        else if (r_depth >= DEPTH_C)
          w_pre_code = ERR_OVF;
      end
      OP_MUL: begin
`ifdef RPN_ALU_MUL_EN
        if (r_depth < CNT_W'(2)) w_pre_code = ERR_UNF;
`else
        w_pre_code = ERR_ILL;
`endif
      end
      default: begin
        if (r_depth < CNT_W'(2)) w_pre_code = ERR_UNF;
      end
    endcase
  end

  // next-state sequencing
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_pre_code == ERR_NONE)
          w_state_nxt = (cmd.op == OP_PUSH) ? S_PUSHR : S_POPB;
      end
      S_POPB:  w_state_nxt = S_CAPB;
      S_CAPB: begin
        if (r_op == OP_POP)
          w_state_nxt = S_IDLE;
        else if (r_op == OP_DUP)
          w_state_nxt = S_PUSHR;
        else
          w_state_nxt = S_CAPA;
      end
      S_CAPA:  w_state_nxt = S_PUSHR;
      S_PUSHR: w_state_nxt = (r_op == OP_DUP) ? S_PUSH2 : S_IDLE;
      S_PUSH2: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // stack strobes and result pulse, all killed by reset
  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_res_valid = 1'b0;
    if (!i_reset) begin
      w_push = (r_state == S_PUSHR) || (r_state == S_PUSH2);
      w_pop  = (r_state == S_POPB) ||
               (r_state == S_CAPB && r_op != OP_POP &&
                r_op != OP_DUP);
      w_res_valid = (r_state == S_CAPB) && (r_op == OP_POP);
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // command latch and operand capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op  <= OP_PUSH;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else begin
      if (w_accept) begin
        r_op <= cmd.op;
        r_b  <= cmd.data;
      end
      if (r_state == S_CAPB) r_b <= i_stk_rdata;
      if (r_state == S_CAPA) r_a <= i_stk_rdata;
      if (w_res_valid)       r_res <= i_stk_rdata;
    end
  end

  // occupancy tracks the strobes actually issued
  always_ff @(posedge i_clk) begin
    if (i_reset)     r_depth <= '0;
    else if (w_push) r_depth <= r_depth + CNT_W'(1);
    else if (w_pop)  r_depth <= r_depth - CNT_W'(1);
  end

  // sticky error, first code wins
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (w_accept && w_pre_code != ERR_NONE) begin
      r_err <= 1'b1;
      if (r_err_code == ERR_NONE) r_err_code <= w_pre_code;
    end
  end

  assign o_stk_push  = w_push;
  assign o_stk_pop   = w_pop;
  assign o_stk_wdata = w_push ? w_exec : '0;
  assign o_res_valid = w_res_valid;
  assign o_res_data  = w_res_valid ? i_stk_rdata : r_res;
  assign o_depth     = r_depth;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

endmodule
